// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Arbitrates one single-port 1bpp framebuffer RAM between the display scan,
// a full-buffer clear sequence and a small write FIFO fed by game logic.
// Display fetches own every 4th active pixel. All other cycles go to the clear
// sequence first and to the FIFO second. Pixel and sync outputs are delayed
// by two cycles so that they line up.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no clear running; free cycles drain the write FIFO
// S_CLEAR | writing zero to one cell per free cycle, FIFO drain paused
module vga_fb_arbiter #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4      // power of 2, at least 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    input  logic              de,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    input  logic              mem_rdata,
    output logic              pix_on,
    output logic              de_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              frame_tick
);
    localparam int                CELLS   = FB_W * FB_H;
    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(CELLS - 1);
    localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic              r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;

    logic              r_fetch_d1;
    logic              r_cell;
    logic              r_pix;
    logic              r_de_d1;
    logic              r_de_d2;
    logic              r_hs_d1;
    logic              r_hs_d2;
    logic              r_vs_d1;
    logic              r_vs_d2;
    logic              r_tick;

    logic [7:0]        w_cell_x;
    logic [7:0]        w_cell_y;
    logic [ADDR_W-1:0] w_row_base;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic              w_fetch;
    logic              w_clr_slot;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic              w_head_ok;
    logic              w_cell_next;
    logic [1:0]        w_unused;

    // Sub-cell row bits of sy never affect the cell address.
    assign w_unused = sy[1:0];

    assign w_cell_x = sx[9:2];
    assign w_cell_y = sy[9:2];
    assign w_fetch  = de && (sx[1:0] == 2'b00);

    // For the standard 160-cell-wide buffer, y*160 is built as y*128 + y*32.
    generate
        if (FB_W == 160) begin : g_row_shift
            assign w_row_base = (ADDR_W'(w_cell_y) << 7) + (ADDR_W'(w_cell_y) << 5);
        end else begin : g_row_mul
            assign w_row_base = ADDR_W'(w_cell_y) * ADDR_W'(FB_W);
        end
    endgenerate

    assign w_fetch_addr = w_row_base + ADDR_W'(w_cell_x);

    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == '0);
    assign wr_ready   = !w_full;
    // A full FIFO refuses the push even if it pops in the same cycle.
    assign w_push     = wr_valid && !w_full;
    assign w_clr_slot = !w_fetch && (r_state == S_CLEAR);
    assign w_pop      = !w_fetch && (r_state == S_IDLE) && !w_empty;
    assign w_head_ok  = (r_fifo_addr[r_rptr] < CELLS_A);

    // Clear FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Clear FSM next state: start on request, stop once the last cell is written
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (clr_start) w_state_next = S_CLEAR;
            S_CLEAR: if (w_clr_slot && (r_clr_cnt == LAST_A)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Clear FSM outputs
    always_comb begin
        clr_busy = (r_state == S_CLEAR);
    end

    // Clear address counter; fetch cycles stall it
    always_ff @(posedge clk) begin
        if (rst)                                  r_clr_cnt <= '0;
        else if ((r_state == S_IDLE) && clr_start) r_clr_cnt <= '0;
        else if (w_clr_slot)                      r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    end

    // Write FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PTR_W + 1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PTR_W + 1)'(1);
        end
    end

    // Write FIFO storage; contents are meaningless until pushed, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= wr_addr;
            r_fifo_data[r_wptr] <= wr_data;
        end
    end

    // RAM port mux: fetch, then clear, then FIFO head, else idle at address 0
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 1'b0;
        if (w_fetch) begin
            mem_addr = w_fetch_addr;
        end else if (w_clr_slot) begin
            mem_addr = r_clr_cnt;
            mem_we   = 1'b1;
        end else if (w_pop) begin
            // Out-of-range heads are dropped: popped with the write suppressed.
            mem_addr  = r_fifo_addr[r_rptr];
            mem_we    = w_head_ok;
            mem_wdata = r_fifo_data[r_rptr];
        end
    end

    // Read data arrives the cycle after a fetch. The cell value is used
    // straight away so that the registered pixel lines up with de_d2.
    assign w_cell_next = r_fetch_d1 ? mem_rdata : r_cell;

    // Pixel and sync alignment pipeline; syncs reset to their inactive level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_d1 <= 1'b0;
            r_cell     <= 1'b0;
            r_pix      <= 1'b0;
            r_de_d1    <= 1'b0;
            r_de_d2    <= 1'b0;
            r_hs_d1    <= 1'b1;
            r_hs_d2    <= 1'b1;
            r_vs_d1    <= 1'b1;
            r_vs_d2    <= 1'b1;
            r_tick     <= 1'b0;
        end else begin
            r_fetch_d1 <= w_fetch;
            r_cell     <= w_cell_next;
            r_pix      <= w_cell_next & r_de_d1;
            r_de_d1    <= de;
            r_de_d2    <= r_de_d1;
            r_hs_d1    <= hsync_in;
            r_hs_d2    <= r_hs_d1;
            r_vs_d1    <= vsync_in;
            r_vs_d2    <= r_vs_d1;
            r_tick     <= (sx == '0) && (sy == '0);
        end
    end

    assign pix_on     = r_pix;
    assign de_out     = r_de_d2;
    assign hsync_out  = r_hs_d2;
    assign vsync_out  = r_vs_d2;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: a VGA position generator, a 1-cycle-latency RAM,
// a behavioural model (write queue, clear counter, delay lines), and directed
// literal checks.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
    localparam int FB_W  = 160;
    localparam int FB_H  = 120;
    localparam int CELLS = FB_W * FB_H;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sx = 10'd700;
    logic [9:0]  sy = 10'd490;
    logic        de, hsync_in, vsync_in;
    logic        wr_valid = 1'b0;
    logic [14:0] wr_addr = '0;
    logic        wr_data = 1'b0;
    logic        wr_ready;
    logic        clr_start = 1'b0;
    logic        clr_busy;
    logic [14:0] mem_addr;
    logic        mem_we, mem_wdata, mem_rdata;
    logic        pix_on, de_out, hsync_out, vsync_out, frame_tick;
    logic        fill_req = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign de       = (sx < 10'd640) && (sy < 10'd480);
    assign hsync_in = !((sx >= 10'd656) && (sx < 10'd752));
    assign vsync_in = !((sy >= 10'd490) && (sy < 10'd492));

    vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(15), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sx(sx), .sy(sy), .de(de),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_on(pix_on), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .frame_tick(frame_tick)
    );

    // Single-port RAM with registered read data; fill_req presets every cell to 1.
    bit   ram [0:32767];
    logic ram_q = 1'b0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_q <= ram[mem_addr];
        if (fill_req) for (int i = 0; i < CELLS; i++) ram[i] <= 1'b1;
    end
    assign mem_rdata = ram_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0d expected %0d at t=%0t (sx=%0d sy=%0d)",
                         name, act, exp, $time, sx, sy);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [14:0] a; logic d; } wr_t;
    wr_t q[$];
    bit  fb_ref [0:CELLS-1];
    bit  m_clr  = 1'b0;
    int  m_cnt  = 0;
    bit  m_last = 1'b0;
    bit  p_pix1 = 1'b0, e_pix = 1'b0;
    bit  e_de1 = 1'b0, e_de = 1'b0;
    bit  e_hs1 = 1'b1, e_hs = 1'b1, e_vs1 = 1'b1, e_vs = 1'b1;
    bit  e_tick = 1'b0;

    always @(negedge clk) begin : model
        bit  fetch, was_clr, rdy;
        int  fa;
        wr_t h;
        if (rst) begin
            q.delete();
            m_clr = 0; m_cnt = 0; m_last = 0;
            p_pix1 = 0; e_pix = 0; e_de1 = 0; e_de = 0;
            e_hs1 = 1; e_hs = 1; e_vs1 = 1; e_vs = 1; e_tick = 0;
        end else begin
            chk("pix_on", pix_on, e_pix);
            chk("de_out", de_out, e_de);
            chk("hsync_out", hsync_out, e_hs);
            chk("vsync_out", vsync_out, e_vs);
            chk("frame_tick", frame_tick, e_tick);
            chk("clr_busy", clr_busy, m_clr);
            rdy = (q.size() < DEPTH);
            chk("wr_ready", wr_ready, rdy);
            was_clr = m_clr;
            fetch = de && (sx % 4 == 0);
            fa = (int'(sy) / 4) * FB_W + int'(sx) / 4;
            if (fetch) begin
                chk("fetch_we", mem_we, 0);
                chk("fetch_addr", mem_addr, fa);
                m_last = fb_ref[fa];
            end else if (m_clr) begin
                chk("clr_we", mem_we, 1);
                chk("clr_addr", mem_addr, m_cnt);
                chk("clr_wdata", mem_wdata, 0);
                fb_ref[m_cnt] = 0;
                if (m_cnt == CELLS - 1) m_clr = 0;
                else m_cnt++;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                if (int'(h.a) < CELLS) begin
                    chk("fifo_we", mem_we, 1);
                    chk("fifo_addr", mem_addr, h.a);
                    chk("fifo_wdata", mem_wdata, h.d);
                    fb_ref[h.a] = h.d;
                end else begin
                    chk("oor_we", mem_we, 0);
                end
            end else begin
                chk("idle_we", mem_we, 0);
                chk("idle_addr", mem_addr, 0);
            end
            if (clr_start && !was_clr) begin m_clr = 1; m_cnt = 0; end
            if (wr_valid && rdy) q.push_back('{a: wr_addr, d: wr_data});
            e_pix = p_pix1; p_pix1 = de & m_last;
            e_de = e_de1;   e_de1 = de;
            e_hs = e_hs1;   e_hs1 = hsync_in;
            e_vs = e_vs1;   e_vs1 = vsync_in;
            e_tick = (sx == 0) && (sy == 0);
        end
        if (fill_req) for (int i = 0; i < CELLS; i++) fb_ref[i] = 1;
    end

    // Counts clear writes (zero data while busy) since the last clr_start.
    int zc = 0;
    always @(negedge clk) begin
        if (clr_start) zc = 0;
        else if (clr_busy && mem_we && !mem_wdata) zc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
        if (sx == 10'd799) begin
            sx = '0;
            sy = (sy == 10'd524) ? 10'd0 : sy + 10'd1;
        end else begin
            sx = sx + 10'd1;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic goto_pos(input int x, input int y);
        sx = 10'(x);
        sy = 10'(y);
    endtask

    int  ticks, ones, first_x, first_y, h1x, h1y, h2x, h2y;
    bit  done;

    initial begin
        steps(3);
        rst = 1'b0;
        // Reset values, including the second sync delay stage.
        @(negedge clk);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_pix_on", pix_on, 0);
        chk("rst_hsync", hsync_out, 1);
        chk("rst_vsync", vsync_out, 1);
        chk("rst_frame_tick", frame_tick, 0);
        step();
        @(negedge clk);
        chk("rst_hsync_stage2", hsync_out, 1);
        step();

        // Frame tick: exactly one pulse around the (0,0) position.
        goto_pos(798, 524);
        ticks = 0;
        repeat (8) begin
            @(negedge clk);
            ticks += int'(frame_tick);
            step();
        end
        chk("frame_tick_count", ticks, 1);

        // Single write of cell (1,1) in blanking.
        goto_pos(0, 500);
        wr_valid = 1; wr_addr = 15'd161; wr_data = 1;
        step();
        wr_valid = 0;
        @(negedge clk);
        chk("single_we", mem_we, 1);
        chk("single_addr", mem_addr, 161);
        chk("single_wdata", mem_wdata, 1);
        step();

        // Scan lines 3..7: pix_on must be 1 for exactly sx 4..7 on lines 4..7.
        goto_pos(0, 3);
        ones = 0; first_x = -1; first_y = -1;
        h1x = 0; h1y = 0; h2x = 0; h2y = 0;
        repeat (5 * 800) begin
            @(negedge clk);
            if (pix_on) begin
                ones++;
                if (first_x < 0) begin first_x = h2x; first_y = h2y; end
            end
            h2x = h1x; h2y = h1y; h1x = int'(sx); h1y = int'(sy);
            step();
        end
        chk("pix_ones", ones, 16);
        chk("pix_first_x", first_x, 4);
        chk("pix_first_y", first_y, 4);

        // Random writes (some out of range) during active video.
        goto_pos(0, 10);
        repeat (3 * 800) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 15'($urandom_range(0, CELLS + 63));
            wr_data  = 1'($urandom_range(0, 1));
            step();
        end
        wr_valid = 0;

        // Out-of-range write in blanking.
        goto_pos(0, 500);
        steps(20);
        wr_valid = 1; wr_addr = 15'(CELLS); wr_data = 1;
        step();
        wr_valid = 0;
        @(negedge clk);
        chk("oor_literal_we", mem_we, 0);
        step();
        @(negedge clk);
        chk("oor_fifo_empty", wr_ready, 1);
        step();

        // Fill RAM with ones, then clear from (0,0) while pushing a burst.
        fill_req = 1;
        step();
        fill_req = 0;
        goto_pos(0, 0);
        clr_start = 1;
        step();
        clr_start = 0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1; wr_addr = 15'(321 + i); wr_data = 1;
            @(negedge clk);
            if (i == 0) chk("clr_busy_rise", clr_busy, 1);
            chk("burst_ready", wr_ready, (i < 4) ? 1 : 0);
            step();
        end
        wr_valid = 0;
        @(negedge clk);
        chk("clr_fifo_held_321", ram[321], 1);  // still the fill value: no drain yet
        done = 0;
        for (int k = 0; k < 40000 && !done; k++) begin
            if (clr_busy) step();
            @(negedge clk);
            if (!clr_busy) done = 1;
        end
        chk("clr_finished", done, 1);
        chk("clr_zero_writes", zc, CELLS);
        ones = 0;
        for (int i = 0; i < CELLS; i++) ones += int'(ram[i]);
        chk("clr_ram_ones", ones, 0);
        step();
        steps(30);
        @(negedge clk);
        chk("after_clr_321", ram[321], 1);
        chk("after_clr_324", ram[324], 1);
        chk("after_clr_325", ram[325], 0);
        step();

        // Reset in the middle of a clear with FIFO entries pending.
        goto_pos(0, 500);
        clr_start = 1;
        step();
        clr_start = 0;
        steps(50);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_addr = 15'(1000 + i); wr_data = 1;
            step();
        end
        wr_valid = 0;
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("midclr_rst_busy", clr_busy, 0);
        chk("midclr_rst_ready", wr_ready, 1);
        step();
        steps(20);
        @(negedge clk);
        chk("midclr_discard_1000", ram[1000], 0);
        chk("midclr_discard_1002", ram[1002], 0);
        step();

        // More random traffic across active video and blanking.
        goto_pos(0, 20);
        repeat (2 * 800) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 15'($urandom_range(0, CELLS + 63));
            wr_data  = 1'($urandom_range(0, 1));
            step();
        end
        wr_valid = 0;
        steps(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
